// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// Holds the FSM state encoding, datapath widths and the direction encoding
// shared with the single-bit shifter.
package shift_seq_pkg;

  localparam int WIDTH = 32;
  localparam int AMT_W = $clog2(WIDTH);

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: drives an external single-bit shifter once per clock.
// Latency: result_valid first high amount+1 cycles after acceptance (1..32).
// Backpressure: result held in HOLD until result_ready; start_ready low outside IDLE.
// Optional feature: define SHIFT_SEQ_ROTATE_EN to enable rotate mode (rot input).
module shift_seq
  import shift_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir,
  input  logic             rot,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] sh_in,
  output logic             sh_dir,
  output logic             sh_en,
  input  logic [WIDTH-1:0] sh_out
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [AMT_W-1:0] cnt;
  logic             dir_q;
  logic [WIDTH-1:0] fill;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_q;

  // Reinsert the bit that the shifter pushes out of the far end.
  always_comb begin
    fill = '0;
    if (rot_q) begin
      if (dir_q == DIR_LEFT) begin
        fill = {{(WIDTH-1){1'b0}}, acc[WIDTH-1]};
      end else begin
        fill = {acc[0], {(WIDTH-1){1'b0}}};
      end
    end
  end

  // Rotate flag is captured only when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if (state == IDLE && start_valid) begin
      rot_q <= rot;
    end
  end
`else
  logic unused_rot;
  assign unused_rot = rot;

  // Logical shifts only: vacated bits stay zero.
  always_comb begin
    fill = '0;
  end
`endif

  // The shifter always sees the accumulator and the captured direction.
  assign sh_in  = acc;
  assign sh_dir = dir_q;
  assign result = acc;

  // Sequencer FSM with registered handshake and shifter-enable outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      dir_q        <= DIR_RIGHT;
      start_ready  <= 1'b1;
      result_valid <= 1'b0;
      sh_en        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            acc         <= operand;
            cnt         <= amount;
            dir_q       <= dir;
            start_ready <= 1'b0;
            if (amount != '0) begin
              state <= RUN;
              sh_en <= 1'b1;
            end else begin
              // Zero-length job goes straight to the result slot.
              state        <= HOLD;
              result_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= sh_out | fill;
          cnt <= cnt - 1'b1;
          // Leave on the last step so cnt never wraps below zero.
          if (cnt == AMT_W'(1)) begin
            state        <= HOLD;
            sh_en        <= 1'b0;
            result_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          start_ready  <= 1'b1;
          result_valid <= 1'b0;
          sh_en        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq with a behavioural single-bit shifter
// and an arithmetic reference model (shift/rotate by amount in one step).
module tb_shift_seq;
  import shift_seq_pkg::*;

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] operand;
  logic [AMT_W-1:0] amount;
  logic             dir;
  logic             rot;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] sh_in;
  logic             sh_dir;
  logic             sh_en;
  logic [WIDTH-1:0] sh_out;

  int n_tests;
  int n_fail;

  shift_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .operand      (operand),
    .amount       (amount),
    .dir          (dir),
    .rot          (rot),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .sh_in        (sh_in),
    .sh_dir       (sh_dir),
    .sh_en        (sh_en),
    .sh_out       (sh_out)
  );

  // Sibling single-bit shifter: outputs 0 when not enabled.
  assign sh_out = sh_en ? (sh_dir ? (sh_in << 1) : (sh_in >> 1)) : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] op, input int amt,
                                        input logic d, input logic r);
    logic [63:0] dbl;
    logic        do_rot;
    do_rot = ROT_EN & r;
    if (amt == 0) return op;
    if (d) begin
      if (do_rot) begin
        dbl = {op, op} << amt;
        return dbl[63:32];
      end
      return op << amt;
    end
    if (do_rot) begin
      dbl = {op, op} >> amt;
      return dbl[31:0];
    end
    return op >> amt;
  endfunction

  // Called at the falling edge of the first cycle after acceptance.
  task automatic wait_result(input logic [31:0] exp, input int amt, input int hold_cyc);
    int lat;
    int en;
    lat = 1;
    en  = 0;
    while (!result_valid && lat < 64) begin
      if (sh_en) en++;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(amt + 1));
    check("sh_en_cycles", 32'(en), 32'(amt));
    check("result", result, exp);
    repeat (hold_cyc) begin
      @(negedge clk);
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_result", result, exp);
      check("hold_no_accept", 32'(start_ready), 32'd0);
      check("hold_sh_en", 32'(sh_en), 32'd0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("idle_ready", 32'(start_ready), 32'd1);
    check("idle_valid", 32'(result_valid), 32'd0);
  endtask

  task automatic run_job(input logic [31:0] op, input int amt, input logic d,
                         input logic r, input int hold_cyc);
    logic [31:0] exp;
    exp = model(op, amt, d, r);
    @(negedge clk);
    check("start_ready", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    operand     = op;
    amount      = AMT_W'(amt);
    dir         = d;
    rot         = r;
    @(negedge clk);
    start_valid = 1'b0;
    // Inputs are sampled only at acceptance; scramble them afterwards.
    operand     = $urandom;
    amount      = AMT_W'($urandom_range(0, 31));
    dir         = 1'($urandom_range(0, 1));
    rot         = 1'($urandom_range(0, 1));
    wait_result(exp, amt, hold_cyc);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    start_valid  = 1'b0;
    operand      = '0;
    amount       = '0;
    dir          = 1'b0;
    rot          = 1'b0;
    result_ready = 1'b0;

    #12;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_sh_en", 32'(sh_en), 32'd0);
    check("rst_sh_dir", 32'(sh_dir), 32'd0);
    check("rst_sh_in", sh_in, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_job(32'h0000_0001, 4, 1'b1, 1'b0, 1);
    run_job(32'h8000_0000, 31, 1'b0, 1'b0, 0);
    run_job(32'hDEAD_BEEF, 0, 1'b0, 1'b0, 2);
    run_job(32'h8000_0001, 1, 1'b1, 1'b1, 0);
    run_job(32'h8000_0001, 1, 1'b0, 1'b1, 0);
    run_job(32'hF000_000F, 31, 1'b1, 1'b1, 0);

    // Backpressure with a pending request held on start_valid.
    @(negedge clk);
    start_valid = 1'b1;
    operand     = 32'h1234_5678;
    amount      = AMT_W'(3);
    dir         = DIR_RIGHT;
    rot         = 1'b0;
    @(negedge clk);
    operand     = 32'hA5A5_0F0F;
    amount      = AMT_W'(5);
    dir         = DIR_LEFT;
    rot         = 1'b1;
    wait_result(model(32'h1234_5678, 3, 1'b0, 1'b0), 3, 10);
    @(negedge clk);
    start_valid = 1'b0;
    check("pending_accepted", 32'(sh_en), 32'd1);
    wait_result(model(32'hA5A5_0F0F, 5, 1'b1, 1'b1), 5, 0);

    // Reset in the middle of a long job.
    @(negedge clk);
    start_valid = 1'b1;
    operand     = 32'h0F0F_1234;
    amount      = AMT_W'(20);
    dir         = DIR_LEFT;
    rot         = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_run_sh_en", 32'(sh_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_start_ready", 32'(start_ready), 32'd1);
    check("mid_rst_result_valid", 32'(result_valid), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_sh_en", 32'(sh_en), 32'd0);
    check("mid_rst_sh_dir", 32'(sh_dir), 32'd0);
    check("mid_rst_sh_in", sh_in, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(32'h0000_000F, 2, 1'b1, 1'b0, 0);
    check("post_rst_value", model(32'h0000_000F, 2, 1'b1, 1'b0), 32'h0000_003C);

    // Randomized jobs.
    for (int i = 0; i < 40; i++) begin
      run_job($urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer in the ALU, directly upstream of the single-bit shifter. It accepts an operand, a shift amount and a direction, then drives the shifter once per clock, registering its output back into an accumulator, until the requested number of one-bit shifts is done. The result is returned over a valid/ready handshake. An optional rotate mode reinserts the bit lost at each step.

## Interface
- WIDTH, 32, datapath width; fixed to match the 32-bit shifter.
- AMT_W, 5, shift-amount width, equal to $clog2(WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- start_valid  in  1  request present.
- start_ready  out  1  sequencer can accept a request.
- operand  in  WIDTH  value to shift.
- amount  in  AMT_W  number of one-bit shifts, 0..31.
- dir  in  1  0 = right, 1 = left (same encoding as the shifter).
- rot  in  1  rotate request; ignored unless SHIFT_SEQ_ROTATE_EN is defined.
- result_valid  out  1  result held and valid.
- result_ready  in  1  consumer takes the result.
- result  out  WIDTH  shifted value.
- sh_in  out  WIDTH  to shifter data input; always equals acc.
- sh_dir  out  1  to shifter direction input; the registered dir.
- sh_en  out  1  to shifter shift input; high only in RUN.
- sh_out  in  WIDTH  shifter combinational output.

## Operation
- FSM states are IDLE, RUN and HOLD. Registers are acc, cnt, dir_q and rot_q.
- IDLE:
  - start_ready = 1.
  - On start_valid: load acc = operand, cnt = amount, dir_q = dir, rot_q = rot.
  - Go to RUN if amount != 0, otherwise go to HOLD.
- RUN:
  - sh_en = 1.
  - Each cycle: acc <= sh_out | fill, and cnt <= cnt - 1.
  - When cnt == 1, go to HOLD.
- fill:
  - Zero, unless rotating.
  - Rotate left: fill = {31'b0, acc[31]}.
  - Rotate right: fill = {acc[0], 31'b0}.
- HOLD:
  - result_valid = 1 and result = acc, both held stable.
  - On result_ready, go to IDLE.
- start_ready is low in RUN and HOLD. A start_valid there is not accepted and has no effect.
- sh_out is used only in RUN. Its value in IDLE or HOLD is don't-care (the shifter outputs 0 when sh_en = 0).
- operand, amount, dir and rot are sampled only at acceptance. Later changes are ignored.

## Timing
- Reset values (asynchronous, held while rst_n = 0):
  - state = IDLE; acc, cnt, dir_q and rot_q are 0.
  - start_ready = 1, result_valid = 0, result = 0.
  - sh_en = 0, sh_dir = 0, sh_in = 0.
- Accepting in cycle t means start_valid & start_ready are sampled at the edge ending t.
  - result_valid is first high in cycle t+amount+1. This holds for every amount, including 0 (latency 1).
  - The maximum is amount 31, giving a 32-cycle latency.
- Result handshake:
  - HOLD→IDLE takes effect at the edge where result_valid & result_ready = 1.
  - The earliest next acceptance is at the following edge, so there is at least one idle cycle between jobs.
- With result_ready held low, HOLD persists indefinitely and result stays unchanged.
- Reset asserted mid-RUN or mid-HOLD drops the job: outputs go to reset values immediately, and no partial result is presented.
- cnt never wraps: the transition to HOLD occurs at cnt == 1.

## Configuration
- SHIFT_SEQ_ROTATE_EN defined:
  - rot_q is registered.
  - fill is applied as described, giving rotate-by-amount.
- SHIFT_SEQ_ROTATE_EN undefined:
  - rot is ignored, rot_q is absent and fill = 0.
  - The block performs logical shifts only; vacated bits are 0.

## Structure
- Shared package shift_seq_pkg holds:
  - the state enum (IDLE, RUN, HOLD);
  - the WIDTH and AMT_W constants;
  - the direction encodings (DIR_RIGHT = 0, DIR_LEFT = 1).
- No sub-module. The single-bit shifter is a sibling instance in the ALU, wired through the sh_* ports.

## Test plan
- Left shift: operand 0x00000001, amount 4, dir 1 → result 0x00000010, result_valid 5 cycles after acceptance, sh_en high for exactly 4 cycles.
- Right shift at maximum amount: operand 0x80000000, amount 31, dir 0 → result 0x00000001 at 32-cycle latency.
- Zero amount: operand 0xDEADBEEF, amount 0 → result 0xDEADBEEF, latency 1, sh_en never asserted.
- Rotate left: operand 0x80000001, amount 1, dir 1, rot 1 → 0x00000003 with SHIFT_SEQ_ROTATE_EN, 0x00000002 without.
- Backpressure: result_ready held low 10 cycles, with start_valid high throughout → result stable, start_ready 0, no new job accepted. Releasing result_ready → IDLE, then the pending request is accepted on the next edge.
- Reset mid-operation: rst_n pulsed low during RUN of an amount-20 job → immediate reset values. A following job (operand 0x0000000F, amount 2, dir 1) produces 0x0000003C.
